// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and baud divider math.
// The divider helper is shared with the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FRAME_DATA_BITS = 8;

  // Integer-floor cycles per bit; 0 flags an unusable CLOCK_HZ/BAUD pair.
  function automatic int calc_div(input int clock_hz, input int baud);
    return (baud > 0) ? (clock_hz / baud) : 0;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word handshake between a CPU/IO word source (master) and the UART word transmitter (slave).
interface uart_word_tx_if;
  logic [15:0] word_i;
  logic        single_byte_i;
  logic        word_valid_i;
  logic        word_ready_o;

  modport master (
    output word_i,
    output single_byte_i,
    output word_valid_i,
    input  word_ready_o
  );

  modport slave (
    input  word_i,
    input  single_byte_i,
    input  word_valid_i,
    output word_ready_o
  );
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..DIV-1 and pulses bit_end on the last cycle of each bit.
module uart_baud_counter #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_end
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV = 1 the count is pinned at 0 and every cycle ends a bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (restart || bit_end)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign bit_end = (cnt == LAST);
endmodule

// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter sending 16-bit words low byte first, or one byte in single-byte mode.
// Define UART_WORD_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ = 6250,
  parameter int BAUD     = 781
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_word_tx_if.slave  wif,
  output logic           tx_o,
  output logic           busy_o
);
  localparam int DIV = calc_div(CLOCK_HZ, BAUD);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_word_tx: CLOCK_HZ/BAUD must give at least one clock per bit");
  end

  state_t      state;
  logic [15:0] hold;
  logic        single_q;
  logic        byte_idx;
  logic [2:0]  bit_cnt;
  logic        tx_q;
  logic        busy_q;
  logic        ready_q;

  logic        accept;
  logic        bit_end;
  logic [7:0]  cur_byte;
  logic [2:0]  next_bit;

  assign accept   = wif.word_valid_i & ready_q;
  assign cur_byte = byte_idx ? hold[15:8] : hold[7:0];
  assign next_bit = bit_cnt + 3'd1;

  assign wif.word_ready_o = ready_q;
  assign tx_o             = tx_q;
  assign busy_o           = busy_q;

  uart_baud_counter #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (accept),
    .bit_end (bit_end)
  );

  // Every output is registered, so the line level for the next bit is chosen one edge ahead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold     <= '0;
      single_q <= 1'b0;
      byte_idx <= 1'b0;
      bit_cnt  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            hold     <= wif.word_i;
            single_q <= wif.single_byte_i;
            byte_idx <= 1'b0;
            state    <= START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_q    <= cur_byte[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_WORD_TX_PARITY_EN
              state <= PARITY;
              tx_q  <= ^cur_byte;
`else
              state <= STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_cnt <= next_bit;
              tx_q    <= cur_byte[next_bit];
            end
          end
        end
`ifdef UART_WORD_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx_q  <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            // The high byte follows the low byte's stop bit with no idle gap.
            if (!byte_idx && !single_q) begin
              byte_idx <= 1'b1;
              state    <= START;
              tx_q     <= 1'b0;
            end else begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: directed and random words against a line-level frame model.
module tb_uart_word_tx;
  localparam int CLOCK_HZ = 6250;
  localparam int BAUD     = 781;
  localparam int DIV      = CLOCK_HZ / BAUD;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif

  typedef logic bitq_t[$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_word_tx_if wif ();
  uart_word_tx_if wif1 ();
  logic tx, busy, tx1, busy1;

  uart_word_tx #(.CLOCK_HZ(CLOCK_HZ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wif     (wif),
    .tx_o    (tx),
    .busy_o  (busy)
  );

  // Second instance at one clock per bit.
  uart_word_tx #(.CLOCK_HZ(6250), .BAUD(6250)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .wif     (wif1),
    .tx_o    (tx1),
    .busy_o  (busy1)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level on every clock after accept: start, 8 data LSB first, [even parity], stop.
  function automatic bitq_t frame_bits(input logic [15:0] w, input bit single, input int div);
    bitq_t levels;
    bitq_t line;
    int nb = single ? 1 : 2;
    for (int b = 0; b < nb; b++) begin
      int v   = (int'(w) >> (8 * b)) & 255;
      int par = 0;
      levels.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
        int bv = (v >> i) & 1;
        par = par ^ bv;
        levels.push_back(bv[0]);
      end
`ifdef UART_WORD_TX_PARITY_EN
      levels.push_back(par[0]);
`endif
      levels.push_back(1'b1);
    end
    foreach (levels[i])
      for (int r = 0; r < div; r++) line.push_back(levels[i]);
    return line;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_for(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_tx"}, k, 32'(tx), 32'd1);
      chk({tag, "_busy"}, k, 32'(busy), 32'd0);
      chk({tag, "_ready"}, k, 32'(wif.word_ready_o), 32'd1);
      step();
    end
  endtask

  // Offer a word, wait (bounded) for accept, then check every cycle of the frame.
  task automatic send_word(input logic [15:0] w, input bit single, input bit keep_valid,
                           input logic [15:0] next_w, input int abort_at,
                           input string tag, output int acc_cyc);
    bitq_t exp = frame_bits(w, single, DIV);
    bit    got = 1'b0;
    logic  r;
    wif.word_i        = w;
    wif.single_byte_i = single;
    wif.word_valid_i  = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      r = wif.word_ready_o;
      step();
      if (r === 1'b1) got = 1'b1;
    end
    acc_cyc = cyc;
    chk({tag, "_accept"}, 0, 32'(got), 32'd1);
    if (!got) begin
      wif.word_valid_i = 1'b0;
      return;
    end
    if (keep_valid) begin
      wif.word_i = next_w;
    end else begin
      wif.word_valid_i  = 1'b0;
      wif.word_i        = 16'($urandom);
      wif.single_byte_i = 1'($urandom);
    end
    for (int k = 0; k < exp.size(); k++) begin
      if (k == abort_at) return;
      chk({tag, "_tx"}, k, 32'(tx), 32'(exp[k]));
      chk({tag, "_busy"}, k, 32'(busy), 32'd1);
      chk({tag, "_ready"}, k, 32'(wif.word_ready_o), 32'd0);
      step();
    end
    chk({tag, "_end_ready"}, exp.size(), 32'(wif.word_ready_o), 32'd1);
    chk({tag, "_end_busy"}, exp.size(), 32'(busy), 32'd0);
    chk({tag, "_end_tx"}, exp.size(), 32'(tx), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    a0, a1, a2, gap;
    bitq_t e1;
    bit    got1;
    logic  r1;
    logic [15:0] rw;
    bit    rs;

    wif.word_i = '0;  wif.single_byte_i = 1'b0;  wif.word_valid_i = 1'b0;
    wif1.word_i = '0; wif1.single_byte_i = 1'b0; wif1.word_valid_i = 1'b0;

    // Reset held for 5 cycles, then idle.
    reset_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rst_tx", k, 32'(tx), 32'd1);
      chk("rst_busy", k, 32'(busy), 32'd0);
      chk("rst_ready", k, 32'(wif.word_ready_o), 32'd0);
    end
    reset_n = 1'b1;
    step();
    chk("rel_ready", 0, 32'(wif.word_ready_o), 32'd1);
    idle_for(4, "idle0");

    // Two-byte word, low byte first.
    send_word(16'h1234, 1'b0, 1'b0, 16'h0000, -1, "w1234", a0);
    idle_for(3, "idle1");

    // Single-byte mode: high byte must never appear on the line.
    send_word(16'hA5FF, 1'b1, 1'b0, 16'h0000, -1, "single", a0);
    idle_for(2 * BITS_PER_BYTE * DIV, "single_after");

    // Back-to-back with valid held high.
    send_word(16'h0001, 1'b0, 1'b1, 16'h8000, -1, "b2b0", a1);
    send_word(16'h8000, 1'b0, 1'b0, 16'h0000, -1, "b2b1", a2);
    chk("b2b_spacing", 0, 32'(a2 - a1), 32'(2 * BITS_PER_BYTE * DIV + 1));
    idle_for(2, "idle2");

`ifdef UART_WORD_TX_PARITY_EN
    send_word(16'hC307, 1'b1, 1'b0, 16'h0000, -1, "par07", a0);
    chk("par07_bit", 0, 32'(frame_bits(16'h0007, 1'b1, 1)[9]), 32'd1);
    send_word(16'h5A03, 1'b1, 1'b0, 16'h0000, -1, "par03", a0);
    idle_for(2, "idle_par");
`endif

    // Random words and modes with random idle gaps.
    for (int n = 0; n < 8; n++) begin
      rw  = 16'($urandom);
      rs  = ($urandom_range(0, 3) == 0);
      send_word(rw, rs, 1'b0, 16'h0000, -1, $sformatf("rnd%0d", n), a0);
      gap = $urandom_range(0, 3);
      idle_for(gap, "rnd_gap");
    end

    // One clock per bit.
    wif1.word_i = 16'h1234; wif1.single_byte_i = 1'b0; wif1.word_valid_i = 1'b1;
    got1 = 1'b0;
    for (int t = 0; t < 10 && !got1; t++) begin
      r1 = wif1.word_ready_o;
      step();
      if (r1 === 1'b1) got1 = 1'b1;
    end
    chk("div1_accept", 0, 32'(got1), 32'd1);
    wif1.word_valid_i = 1'b0;
    e1 = frame_bits(16'h1234, 1'b0, 1);
    for (int k = 0; k < e1.size(); k++) begin
      chk("div1_tx", k, 32'(tx1), 32'(e1[k]));
      chk("div1_busy", k, 32'(busy1), 32'd1);
      step();
    end
    chk("div1_end_ready", 0, 32'(wif1.word_ready_o), 32'd1);
    chk("div1_end_busy", 0, 32'(busy1), 32'd0);

    // Reset in the middle of data bit 3 of the high byte (0x12 bit 3 = 0).
    send_word(16'h1234, 1'b0, 1'b0, 16'h0000,
              (BITS_PER_BYTE + 1 + 3) * DIV + DIV / 2, "pre_rst", a0);
    chk("mid_tx_low", 0, 32'(tx), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("async_tx", 0, 32'(tx), 32'd1);
    chk("async_busy", 0, 32'(busy), 32'd0);
    chk("async_ready", 0, 32'(wif.word_ready_o), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", 0, 32'(wif.word_ready_o), 32'd1);
    idle_for(2 * BITS_PER_BYTE * DIV, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
